// File: rtl/linreg_pkg.sv
// Shared types and width helpers for the streaming linear-regression engine.
package linreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    PREP,
    DIV1,
    B0P,
    DIV0,
    DONE
  } state_e;

  function automatic int cnt_w(input int max_n);
    return $clog2(max_n + 1);
  endfunction

  function automatic int coef_w(input int data_w, input int frac_w);
    return data_w + frac_w + 2;
  endfunction

  function automatic int div_w(input int data_w, input int count_w, input int frac_w);
    return 2 * (2 * data_w + count_w) + frac_w + 1;
  endfunction

  // Clamp a signed quotient (up to 64 bits) to the signed range of a cw-bit coefficient.
  function automatic logic signed [63:0] sat_coef(input logic signed [63:0] v, input int cw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (cw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/linreg_divider.sv
// Restoring signed divider on magnitudes, one quotient bit per cycle, DW cycles from start to done.
// The start cycle already retires the first quotient bit so the caller can leave on the DW-th edge.
module linreg_divider #(
  parameter int DW = 59
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic signed [DW-1:0] num_i,
  input  logic signed [DW-1:0] den_i,
  output logic                 done_o,
  output logic signed [DW-1:0] quot_o
);

  localparam int CW = $clog2(DW + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] q_q;
  logic [DW-1:0] d_q;
  logic          neg_q;

  logic [DW-1:0]   num_mag;
  logic [DW-1:0]   den_mag;
  logic [2*DW-1:0] first_w;
  logic [2*DW-1:0] next_w;

  // Partial remainder stays below the divisor, so the difference fits back in DW bits.
  function automatic logic [2*DW-1:0] step(input logic [DW-1:0] r, input logic [DW-1:0] q,
                                           input logic [DW-1:0] d);
    logic [DW:0] t;
    t = {r, q[DW-1]};
    if (t >= {1'b0, d}) return {t[DW-1:0] - d, q[DW-2:0], 1'b1};
    return {t[DW-1:0], q[DW-2:0], 1'b0};
  endfunction

  assign num_mag = num_i[DW-1] ? -num_i : num_i;
  assign den_mag = den_i[DW-1] ? -den_i : den_i;
  assign first_w = step('0, num_mag, den_mag);
  assign next_w  = step(rem_q, q_q, d_q);
  assign done_o  = busy_q && (cnt_q == '0);
  assign quot_o  = neg_q ? -q_q : q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      d_q    <= '0;
      neg_q  <= 1'b0;
    end else if (start_i) begin
      busy_q         <= 1'b1;
      cnt_q          <= CW'(DW - 1);
      {rem_q, q_q}   <= first_w;
      d_q            <= den_mag;
      neg_q          <= num_i[DW-1] ^ den_i[DW-1];
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q        <= cnt_q - CW'(1);
        {rem_q, q_q} <= next_w;
      end
    end
  end

endmodule

// File: rtl/linreg_coeff_unit.sv
// Streaming least-squares slope/intercept engine with one shared divider.
// Define LINREG_SAT_EN to clamp out-of-range coefficients instead of wrapping them.
module linreg_coeff_unit
  import linreg_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  MAX_N  = 256,
  parameter int  FRAC_W = 8,
  localparam int CNT_W  = cnt_w(MAX_N),
  localparam int COEF_W = coef_w(DATA_W, FRAC_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        x,
  input  logic [DATA_W-1:0]        y,
  input  logic                     last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] b1,
  output logic signed [COEF_W-1:0] b0,
  output logic                     err,
  output logic                     busy
);

  localparam int DW = div_w(DATA_W, CNT_W, FRAC_W);
  localparam int SW = DATA_W + CNT_W;
  localparam int PW = 2 * DATA_W + CNT_W;
  localparam int XW = 2 * DATA_W;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         n_q, n_d, n_next;
  logic [SW-1:0]            sx_q, sx_d, sy_q, sy_d;
  logic [PW-1:0]            sxy_q, sxy_d, sxx_q, sxx_d;
  logic signed [COEF_W-1:0] b1_q, b1_d, b0_q, b0_d;
  logic                     err_q, err_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic [XW-1:0]        xy_w, xx_w;
  logic signed [DW-1:0] n_s, sx_s, sy_s, sxy_s, sxx_s;
  logic signed [DW-1:0] num1_w, den_w, num0_w;
  logic                 accept;
  logic                 div_start, div_done;
  logic signed [DW-1:0] div_num, div_den, div_quot;

  function automatic logic signed [COEF_W-1:0] to_coef(input logic signed [DW-1:0] q);
`ifdef LINREG_SAT_EN
    return COEF_W'(sat_coef(64'(q), COEF_W));
`else
    return q[COEF_W-1:0];
`endif
  endfunction

  assign xy_w   = XW'(x) * XW'(y);
  assign xx_w   = XW'(x) * XW'(x);
  assign accept = in_valid && in_ready_q;

  assign n_s   = DW'(n_q);
  assign sx_s  = DW'(sx_q);
  assign sy_s  = DW'(sy_q);
  assign sxy_s = DW'(sxy_q);
  assign sxx_s = DW'(sxx_q);

  // Intercept reuses the full-width slope quotient still held by the divider during B0P.
  assign num1_w = (n_s * sxy_s - sx_s * sy_s) <<< FRAC_W;
  assign den_w  = n_s * sxx_s - sx_s * sx_s;
  assign num0_w = (sy_s <<< FRAC_W) - div_quot * sx_s;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    sxy_d       = sxy_q;
    sxx_d       = sxx_q;
    b1_d        = b1_q;
    b0_d        = b0_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    div_start   = 1'b0;
    div_num     = num1_w;
    div_den     = den_w;
    n_next      = (state_q == IDLE) ? CNT_W'(1) : n_q + CNT_W'(1);

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          n_d = n_next;
          if (state_q == IDLE) begin
            sx_d  = SW'(x);
            sy_d  = SW'(y);
            sxy_d = PW'(xy_w);
            sxx_d = PW'(xx_w);
          end else begin
            sx_d  = sx_q + SW'(x);
            sy_d  = sy_q + SW'(y);
            sxy_d = sxy_q + PW'(xy_w);
            sxx_d = sxx_q + PW'(xx_w);
          end
          state_d = (last || n_next == CNT_W'(MAX_N)) ? PREP : ACC;
        end
      end
      PREP: begin
        if (den_w == '0) begin
          err_d       = 1'b1;
          b1_d        = '0;
          b0_d        = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          err_d     = 1'b0;
          div_start = 1'b1;
          state_d   = DIV1;
        end
      end
      DIV1: begin
        if (div_done) begin
          b1_d    = to_coef(div_quot);
          state_d = B0P;
        end
      end
      B0P: begin
        div_start = 1'b1;
        div_num   = num0_w;
        div_den   = n_s;
        state_d   = DIV0;
      end
      DIV0: begin
        if (div_done) begin
          b0_d        = to_coef(div_quot);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == ACC);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      sxy_q       <= '0;
      sxx_q       <= '0;
      b1_q        <= '0;
      b0_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sxy_q       <= sxy_d;
      sxx_q       <= sxx_d;
      b1_q        <= b1_d;
      b0_q        <= b0_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  linreg_divider #(.DW(DW)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign b1        = b1_q;
  assign b0        = b0_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: doc/linreg_coeff_unit.md
# linreg_coeff_unit

Parametrised streaming linear-regression engine: accepts (x, y) samples over a valid/ready handshake, accumulates n, Σx, Σy, Σxy and Σx² on the fly, then computes slope B1 and intercept B0 in signed fixed point with a shared sequential divider. It is the next generation of the coefficient control unit. The fixed two-state load/increment controller becomes a full FSM with bounded sample count, degenerate-input detection and an output handshake, and it sits between the sample source and the result consumer in the regression pipeline.

## Interface
- DATA_W, 8: unsigned width of x and y.
- MAX_N, 256: maximum samples per batch; CNT_W = $clog2(MAX_N+1).
- FRAC_W, 8: fractional bits of B1/B0; COEF_W = DATA_W+FRAC_W+2.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  unit accepts a sample this cycle.
- x, y  in  DATA_W each  sample operands, unsigned.
- last  in  1  qualifies the final sample of the batch.
- out_valid  out  1  b1/b0/err valid.
- out_ready  in  1  consumer takes result.
- b1, b0  out  COEF_W  signed Q(COEF_W-FRAC_W).FRAC_W coefficients.
- err  out  1  degenerate batch (denominator zero).
- busy  out  1  high in every state except IDLE.

## Operation
- Reset: state IDLE; accumulators, counter, b1, b0, err, out_valid, busy = 0; in_ready = 1.
- IDLE: in_ready=1; an accepted sample loads n=1 and accumulators from that sample (no clear cycle), then goes to ACC, or to PREP if last.
- ACC: in_ready=1; each accepted sample: n+=1, Σx+=x, Σy+=y, Σxy+=x·y, Σx²+=x². Exit to PREP on acceptance with last=1, or when n reaches MAX_N (that sample is treated as last).
- PREP (1 cycle): registers NUM1=(n·Σxy−Σx·Σy)·2^FRAC_W and DEN=n·Σx²−(Σx)². If DEN==0, set err=1, b1=b0=0, and go to DONE. Otherwise go to DIV1.
- DIV1: divider computes B1=NUM1/DEN; quotient is truncated toward zero.
- B0P (1 cycle): NUM0=Σy·2^FRAC_W − B1·Σx, with DEN0=n.
- DIV0: B0=NUM0/n, truncated toward zero. Go to DONE.
- DONE: out_valid=1 and outputs stable. On out_ready=1, clear out_valid and return to IDLE; accumulators clear on the next load.
- in_ready=0 in PREP, DIV1, B0P, DIV0 and DONE.
- All intermediates use full width, with no internal overflow. Divider width DW = 2·(2·DATA_W+CNT_W)+FRAC_W+1.
- rst mid-batch or mid-division aborts immediately. The cycle after rst shows reset values. A partial batch is discarded.
- Simultaneous in_valid with out_ready in DONE: the sample is not accepted (in_ready=0 that cycle).

## Timing
- Throughput: 1 sample/cycle in IDLE/ACC.
- Divider: restoring, 1 quotient bit/cycle, DW cycles per division; signs handled on magnitudes.
- Latency: out_valid rises 2·DW+3 cycles after the edge that accepts the last sample.
- Degenerate batch: out_valid rises 2 cycles after that edge.
- Outputs are registered and held while out_valid=1 and out_ready=0.

## Configuration
- LINREG_SAT_EN defined: b1/b0 quotients outside the COEF_W signed range clamp to the max/min representable value.
- LINREG_SAT_EN undefined: only the low COEF_W bits are kept (two's-complement wrap).
- err is unaffected by this macro.

## Structure
- Package linreg_pkg holds:
  - the state enum (IDLE, ACC, PREP, DIV1, B0P, DIV0, DONE);
  - width functions for CNT_W, COEF_W and DW;
  - the saturation helper function.
- One sub-module, linreg_divider: parametrised on DW. Handshake is start/done; it takes signed numerator/denominator and returns a truncated signed quotient. It is instantiated once and shared by DIV1 and DIV0.

## Test plan
- Samples (1,3),(2,5),(3,7) with last on the third: b1=512, b0=256, err=0, out_valid exactly 2·DW+3 cycles after last.
- Samples (0,10),(10,0): b1=−256, b0=2560.
- Samples (0,0),(3,1): b1=85, b0=0, confirming truncation toward zero.
- All x=5 over 4 samples: err=1, b1=b0=0, out_valid 2 cycles after last.
- MAX_N=4, 4 samples with last never asserted: in_ready falls after the 4th sample and the result is computed. Hold out_ready=0 for 10 cycles: outputs stay stable, then IDLE one cycle after out_ready=1.
- rst pulsed during DIV1: next cycle IDLE, out_valid=0, in_ready=1. A fresh 3-sample batch then yields the correct result.
